// File: rtl/trace_fifo_core_if.sv
// trace_fifo_core_if
// Sample/pop channel between the trace FIFO core and its producer/consumer.
//   sample_i       : sensor sample word           (master -> core)
//   sample_valid_i : sample_i valid this cycle    (master -> core)
//   rd_en_i        : one-cycle pop request        (master -> core)
//   rd_data_o      : popped word, held until next (core -> master)
//   rd_valid_o     : one-cycle pulse on update    (core -> master)
interface trace_fifo_core_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] sample_i;
    logic                  sample_valid_i;
    logic                  rd_en_i;
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic                  rd_valid_o;

    modport master (
        output sample_i,
        output sample_valid_i,
        output rd_en_i,
        input  rd_data_o,
        input  rd_valid_o
    );

    modport slave (
        input  sample_i,
        input  sample_valid_i,
        input  rd_en_i,
        output rd_data_o,
        output rd_valid_o
    );
endinterface

// File: rtl/trace_fifo_core.sv
// trace_fifo_core
// Circular sample buffer: once armed and triggered it captures up to len_eff
// sensor words, then hands them out one per pop.
// Ports:
//   ACLK, ARESETN   : clock, asynchronous active-low reset
//   clear_i         : flush pointers/flags, FSM back to IDLE (one-cycle pulse)
//   start_i         : arm a capture, latches capture_len_i (one-cycle pulse)
//   trigger_i       : capture begins on first high cycle while ARMED
//   capture_len_i   : samples to capture, 0 = full depth
//   bus (slave)     : sample write channel and pop/read-data channel
//   count_o         : words currently stored
//   empty_o, full_o : pointer-derived flags
//   overflow_o      : sticky, a sample was dropped because the buffer was full
//   done_o, state_o : FSM status (IDLE=0, ARMED=1, CAPTURE=2, DONE=3)
module trace_fifo_core #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic                  trigger_i,
    input  logic [ADDR_WIDTH:0]   capture_len_i,
    trace_fifo_core_if.slave      bus,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  overflow_o,
    output logic                  done_o,
    output logic [1:0]            state_o
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr, captured, len_eff;
    logic                  cap_window, wr_acc, wr_drop, rd_acc, start_acc;
    logic [DATA_WIDTH-1:0] rd_data_p0;
    logic                  vld_p0;

    // MSB of each pointer is the wrap bit, so equal addresses with differing
    // wrap bits means full rather than empty.
    assign count_o = wr_ptr - rd_ptr;
    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                     (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

    // The trigger cycle itself already stores its sample.
    assign cap_window = !clear_i &&
                        ((state == ST_CAPTURE) || ((state == ST_ARMED) && trigger_i));
    assign wr_acc     = cap_window && bus.sample_valid_i && !full_o && (captured < len_eff);
    assign wr_drop    = cap_window && bus.sample_valid_i && full_o;
    assign rd_acc     = !clear_i && bus.rd_en_i && !empty_o;
    // start is only honoured when no capture is in progress.
    assign start_acc  = !clear_i && start_i && ((state == ST_IDLE) || (state == ST_DONE));

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear_i) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (start_i) state_nxt = ST_ARMED;
                ST_ARMED:   if (trigger_i) state_nxt = wr_drop ? ST_DONE : ST_CAPTURE;
                ST_CAPTURE: if (wr_drop || (captured == len_eff)) state_nxt = ST_DONE;
                ST_DONE:    if (start_i) state_nxt = ST_ARMED;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        done_o  = (state == ST_DONE);
        state_o = state;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            captured   <= '0;
            len_eff    <= DEPTH_W;
            overflow_o <= 1'b0;
        end else if (clear_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            captured   <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            if (start_acc) begin
                captured <= '0;
                len_eff  <= (capture_len_i == '0) ? DEPTH_W : capture_len_i;
            end else if (wr_acc) begin
                captured <= captured + 1'b1;
            end
            if (wr_drop) overflow_o <= 1'b1;
        end
    end

    // Stage p0: block RAM write port and registered read port.
    always_ff @(posedge ACLK) begin
        if (wr_acc) mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.sample_i;
        if (rd_acc) rd_data_p0 <= mem[rd_ptr[ADDR_WIDTH-1:0]];
    end

    // Stage p1: output register, holds the last popped word between pops.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            vld_p0         <= 1'b0;
            bus.rd_valid_o <= 1'b0;
            bus.rd_data_o  <= '0;
        end else if (clear_i) begin
            vld_p0         <= 1'b0;
            bus.rd_valid_o <= 1'b0;
            bus.rd_data_o  <= '0;
        end else begin
            vld_p0         <= rd_acc;
            bus.rd_valid_o <= vld_p0;
            if (vld_p0) bus.rd_data_o <= rd_data_p0;
        end
    end
endmodule

// File: tb/tb_trace_fifo_core.sv
module tb_trace_fifo_core;
    localparam int DW = 32;
    localparam int AW = 10;
    localparam int DEPTH = 1024;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic          clear_i, start_i, trigger_i;
    logic [AW:0]   capture_len_i;
    logic [AW:0]   count_o;
    logic          empty_o, full_o, overflow_o, done_o;
    logic [1:0]    state_o;

    trace_fifo_core_if #(.DATA_WIDTH(DW)) bus();

    trace_fifo_core #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .clear_i       (clear_i),
        .start_i       (start_i),
        .trigger_i     (trigger_i),
        .capture_len_i (capture_len_i),
        .bus           (bus),
        .count_o       (count_o),
        .empty_o       (empty_o),
        .full_o        (full_o),
        .overflow_o    (overflow_o),
        .done_o        (done_o),
        .state_o       (state_o)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural reference: stored words as a queue, capture phase as a
    // number (0 idle, 1 armed, 2 capturing, 3 done), read pipeline as two slots.
    logic [DW-1:0] mq[$];
    int            m_phase, m_len, m_cap;
    bit            m_ovf, m_pv, m_rv;
    logic [DW-1:0] m_pd, m_rd;

    task automatic model_reset();
        mq.delete();
        m_phase = 0; m_len = DEPTH; m_cap = 0;
        m_ovf = 0; m_pv = 0; m_rv = 0; m_pd = '0; m_rd = '0;
    endtask

    task automatic model_edge();
        int  sz;
        int  cap0;
        bit  win, wr, drop, pop;
        if (clear_i) begin
            mq.delete();
            m_phase = 0; m_cap = 0; m_ovf = 0; m_pv = 0; m_rv = 0; m_rd = '0;
            return;
        end
        sz   = mq.size();
        cap0 = m_cap;
        m_rv = m_pv;
        if (m_pv) m_rd = m_pd;
        m_pv = 0;
        win  = (m_phase == 2) || (m_phase == 1 && trigger_i);
        wr   = win && bus.sample_valid_i && (sz < DEPTH) && (m_cap < m_len);
        drop = win && bus.sample_valid_i && (sz == DEPTH);
        pop  = bus.rd_en_i && (sz > 0);
        if (pop) begin m_pd = mq.pop_front(); m_pv = 1; end
        if (wr) begin mq.push_back(bus.sample_i); m_cap++; end
        if (drop) m_ovf = 1;
        case (m_phase)
            0, 3: if (start_i) begin
                m_phase = 1; m_cap = 0;
                m_len = (capture_len_i == 0) ? DEPTH : int'(capture_len_i);
            end
            1: if (trigger_i) m_phase = drop ? 3 : 2;
            2: if (drop || cap0 == m_len) m_phase = 3;
            default: ;
        endcase
    endtask

    task automatic tick();
        model_edge();
        @(posedge ACLK);
        #1;
    endtask

    task automatic idle_inputs();
        clear_i = 0; start_i = 0; trigger_i = 0;
        bus.sample_valid_i = 0; bus.rd_en_i = 0;
    endtask

    task automatic do_clear();
        idle_inputs();
        clear_i = 1;
        tick();
        clear_i = 0;
    endtask

    task automatic test_reset();
        n_checks++; if (count_o !== 11'd0) begin n_fail++; $display("FAIL reset_count got=%0d want=0", count_o); end
        n_checks++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b want=1", empty_o); end
        n_checks++; if (full_o !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b want=0", full_o); end
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b want=0", overflow_o); end
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done_o); end
        n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d want=0", state_o); end
        n_checks++; if (bus.rd_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got=%b want=0", bus.rd_valid_o); end
        n_checks++; if (bus.rd_data_o !== 32'd0) begin n_fail++; $display("FAIL reset_rd_data got=%0h want=0", bus.rd_data_o); end
    endtask

    task automatic test_len4();
        do_clear();
        start_i = 1; capture_len_i = 11'd4;
        tick();
        start_i = 0; capture_len_i = 11'd9;   // later changes must not matter
        trigger_i = 1;
        for (int i = 1; i <= 5; i++) begin
            bus.sample_i = 32'(i); bus.sample_valid_i = 1;
            tick();
        end
        idle_inputs();
        n_checks++; if (count_o !== 11'd4) begin n_fail++; $display("FAIL len4_count got=%0d want=4", count_o); end
        n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL len4_done got=%b want=1", done_o); end
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL len4_overflow got=%b want=0", overflow_o); end
        for (int k = 0; k < 4; k++) begin
            bus.rd_en_i = 1;
            tick();
            bus.rd_en_i = 0;
            n_checks++; if (bus.rd_valid_o !== 1'b0) begin n_fail++; $display("FAIL len4_valid_early pop=%0d got=%b want=0", k, bus.rd_valid_o); end
            tick();
            n_checks++; if (bus.rd_valid_o !== 1'b1) begin n_fail++; $display("FAIL len4_valid pop=%0d got=%b want=1", k, bus.rd_valid_o); end
            n_checks++; if (bus.rd_data_o !== 32'(k + 1)) begin n_fail++; $display("FAIL len4_data pop=%0d got=%0d want=%0d", k, bus.rd_data_o, k + 1); end
        end
        n_checks++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL len4_empty got=%b want=1", empty_o); end
    endtask

    task automatic test_idle_armed();
        do_clear();
        bus.sample_valid_i = 1;
        for (int i = 0; i < 3; i++) begin
            bus.sample_i = $urandom;
            tick();
            n_checks++; if (count_o !== 11'd0) begin n_fail++; $display("FAIL idle_count got=%0d want=0", count_o); end
        end
        start_i = 1; capture_len_i = 11'd3;
        tick();
        start_i = 0;
        for (int i = 0; i < 3; i++) begin
            bus.sample_i = $urandom;
            tick();
            n_checks++; if (count_o !== 11'd0) begin n_fail++; $display("FAIL armed_count got=%0d want=0", count_o); end
        end
        n_checks++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL armed_state got=%0d want=1", state_o); end
        trigger_i = 1; bus.sample_i = 32'hA5A5;
        tick();
        idle_inputs();
        n_checks++; if (count_o !== 11'd1) begin n_fail++; $display("FAIL trig_count got=%0d want=1", count_o); end
        n_checks++; if (state_o !== 2'd2) begin n_fail++; $display("FAIL trig_state got=%0d want=2", state_o); end
        bus.rd_en_i = 1;
        tick();
        bus.rd_en_i = 0;
        tick();
        n_checks++; if (bus.rd_data_o !== 32'hA5A5) begin n_fail++; $display("FAIL trig_data got=%0h want=a5a5", bus.rd_data_o); end
    endtask

    task automatic test_full();
        do_clear();
        start_i = 1; capture_len_i = 11'd0;
        tick();
        start_i = 0; trigger_i = 1; bus.sample_valid_i = 1;
        for (int i = 0; i < 1100; i++) begin
            bus.sample_i = 32'(i);
            tick();
        end
        idle_inputs();
        n_checks++; if (count_o !== 11'd1024) begin n_fail++; $display("FAIL full_count got=%0d want=1024", count_o); end
        n_checks++; if (full_o !== 1'b1) begin n_fail++; $display("FAIL full_flag got=%b want=1", full_o); end
        n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL full_overflow got=%b want=1", overflow_o); end
        n_checks++; if (state_o !== 2'd3) begin n_fail++; $display("FAIL full_state got=%0d want=3", state_o); end
        bus.rd_en_i = 1;
        tick();
        bus.rd_en_i = 0;
        tick();
        n_checks++; if (bus.rd_data_o !== 32'd0) begin n_fail++; $display("FAIL full_first_pop got=%0d want=0", bus.rd_data_o); end
        n_checks++; if (count_o !== 11'd1023) begin n_fail++; $display("FAIL full_after_pop got=%0d want=1023", count_o); end
    endtask

    // Runs straight after test_full: buffer holds 1023 words with overflow set.
    task automatic test_clear();
        start_i = 1; capture_len_i = 11'd0;
        tick();
        start_i = 0; trigger_i = 1; bus.sample_valid_i = 1; bus.sample_i = 32'd7;
        tick();
        idle_inputs();
        n_checks++; if (state_o !== 2'd2) begin n_fail++; $display("FAIL clear_pre_state got=%0d want=2", state_o); end
        n_checks++; if (full_o !== 1'b1) begin n_fail++; $display("FAIL clear_pre_full got=%b want=1", full_o); end
        clear_i = 1; bus.sample_valid_i = 1;
        tick();
        idle_inputs();
        n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL clear_state got=%0d want=0", state_o); end
        n_checks++; if (count_o !== 11'd0) begin n_fail++; $display("FAIL clear_count got=%0d want=0", count_o); end
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL clear_overflow got=%b want=0", overflow_o); end
        n_checks++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL clear_empty got=%b want=1", empty_o); end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] got[$];
        do_clear();
        start_i = 1; capture_len_i = 11'd1000;
        tick();
        start_i = 0; trigger_i = 1; bus.sample_valid_i = 1;
        for (int i = 0; i < 1000; i++) begin
            bus.sample_i = 32'h1000 + 32'(i);
            tick();
        end
        idle_inputs();
        tick();
        n_checks++; if (state_o !== 2'd3) begin n_fail++; $display("FAIL wrap_cap_state got=%0d want=3", state_o); end
        n_checks++; if (count_o !== 11'd1000) begin n_fail++; $display("FAIL wrap_cap_count got=%0d want=1000", count_o); end
        for (int i = 0; i <= 1000; i++) begin
            bus.rd_en_i = (i < 1000);
            tick();
            if (i >= 1) begin
                n_checks++; if (bus.rd_valid_o !== 1'b1) begin n_fail++; $display("FAIL wrap_b2b_valid i=%0d got=%b want=1", i, bus.rd_valid_o); end
                n_checks++; if (bus.rd_data_o !== 32'h1000 + 32'(i - 1)) begin n_fail++; $display("FAIL wrap_b2b_data i=%0d got=%0h want=%0h", i, bus.rd_data_o, 32'h1000 + 32'(i - 1)); end
            end
        end
        idle_inputs();
        n_checks++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL wrap_drained got=%b want=1", empty_o); end
        start_i = 1; capture_len_i = 11'd100;
        tick();
        start_i = 0;
        for (int j = 0; j < 100; j++) begin
            trigger_i = 1; bus.sample_valid_i = 1; bus.sample_i = 32'(j); bus.rd_en_i = 1;
            tick();
            if (bus.rd_valid_o) got.push_back(bus.rd_data_o);
            if (j >= 1) begin
                n_checks++; if (count_o !== 11'd1) begin n_fail++; $display("FAIL wrap_overlap_count j=%0d got=%0d want=1", j, count_o); end
            end
        end
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            bus.rd_en_i = (k == 0);
            tick();
            if (bus.rd_valid_o) got.push_back(bus.rd_data_o);
        end
        n_checks++; if (got.size() != 100) begin n_fail++; $display("FAIL wrap_pop_total got=%0d want=100", got.size()); end
        for (int k = 0; k < got.size() && k < 100; k++) begin
            n_checks++; if (got[k] !== 32'(k)) begin n_fail++; $display("FAIL wrap_data k=%0d got=%0d want=%0d", k, got[k], k); end
        end
    endtask

    task automatic test_pop_empty();
        do_clear();
        start_i = 1; capture_len_i = 11'd1;
        tick();
        start_i = 0; trigger_i = 1; bus.sample_valid_i = 1; bus.sample_i = 32'h55;
        tick();
        idle_inputs();
        bus.rd_en_i = 1;
        tick();
        bus.rd_en_i = 0;
        tick();
        n_checks++; if (bus.rd_data_o !== 32'h55) begin n_fail++; $display("FAIL pe_setup_data got=%0h want=55", bus.rd_data_o); end
        bus.rd_en_i = 1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.rd_en_i = 0;
            tick();
            n_checks++; if (bus.rd_valid_o !== 1'b0) begin n_fail++; $display("FAIL pe_valid i=%0d got=%b want=0", i, bus.rd_valid_o); end
            n_checks++; if (bus.rd_data_o !== 32'h55) begin n_fail++; $display("FAIL pe_data i=%0d got=%0h want=55", i, bus.rd_data_o); end
        end
    endtask

    task automatic test_random();
        do_clear();
        for (int c = 0; c < 3000; c++) begin
            clear_i = ($urandom_range(0, 199) == 0);
            start_i = ($urandom_range(0, 24) == 0);
            capture_len_i = 11'($urandom_range(0, 40));
            trigger_i = ($urandom_range(0, 3) == 0);
            bus.sample_valid_i = $urandom_range(0, 1);
            bus.sample_i = $urandom;
            bus.rd_en_i = ($urandom_range(0, 2) == 0);
            tick();
            n_checks++; if (count_o !== 11'(mq.size())) begin n_fail++; $display("FAIL rnd_count c=%0d got=%0d want=%0d", c, count_o, mq.size()); end
            n_checks++; if (state_o !== 2'(m_phase)) begin n_fail++; $display("FAIL rnd_state c=%0d got=%0d want=%0d", c, state_o, m_phase); end
            n_checks++; if (done_o !== (m_phase == 3)) begin n_fail++; $display("FAIL rnd_done c=%0d got=%b want=%b", c, done_o, m_phase == 3); end
            n_checks++; if (overflow_o !== m_ovf) begin n_fail++; $display("FAIL rnd_overflow c=%0d got=%b want=%b", c, overflow_o, m_ovf); end
            n_checks++; if (bus.rd_valid_o !== m_rv) begin n_fail++; $display("FAIL rnd_rd_valid c=%0d got=%b want=%b", c, bus.rd_valid_o, m_rv); end
            n_checks++; if (bus.rd_data_o !== m_rd) begin n_fail++; $display("FAIL rnd_rd_data c=%0d got=%0h want=%0h", c, bus.rd_data_o, m_rd); end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        do_clear();
        start_i = 1; capture_len_i = 11'd50;
        tick();
        start_i = 0; trigger_i = 1; bus.sample_valid_i = 1; bus.rd_en_i = 1;
        for (int i = 0; i < 20; i++) begin
            bus.sample_i = 32'(i + 1);
            tick();
        end
        n_checks++; if (bus.rd_data_o === 32'd0) begin n_fail++; $display("FAIL ar_pre_data got=%0h want=nonzero", bus.rd_data_o); end
        #3;
        ARESETN = 0;
        model_reset();
        #1;
        n_checks++; if (count_o !== 11'd0) begin n_fail++; $display("FAIL ar_count got=%0d want=0", count_o); end
        n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL ar_state got=%0d want=0", state_o); end
        n_checks++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL ar_empty got=%b want=1", empty_o); end
        n_checks++; if (full_o !== 1'b0) begin n_fail++; $display("FAIL ar_full got=%b want=0", full_o); end
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL ar_overflow got=%b want=0", overflow_o); end
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL ar_done got=%b want=0", done_o); end
        n_checks++; if (bus.rd_valid_o !== 1'b0) begin n_fail++; $display("FAIL ar_rd_valid got=%b want=0", bus.rd_valid_o); end
        n_checks++; if (bus.rd_data_o !== 32'd0) begin n_fail++; $display("FAIL ar_rd_data got=%0h want=0", bus.rd_data_o); end
        @(posedge ACLK);
        #1;
        idle_inputs();
        ARESETN = 1;
        bus.rd_en_i = 1;
        tick();
        tick();
        idle_inputs();
        n_checks++; if (count_o !== 11'd0) begin n_fail++; $display("FAIL ar_post_count got=%0d want=0", count_o); end
        n_checks++; if (bus.rd_valid_o !== 1'b0) begin n_fail++; $display("FAIL ar_post_valid got=%b want=0", bus.rd_valid_o); end
        n_checks++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL ar_post_state got=%0d want=0", state_o); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        capture_len_i = '0;
        bus.sample_i = '0;
        model_reset();
        ARESETN = 0;
        repeat (3) @(posedge ACLK);
        #1;
        ARESETN = 1;
        test_reset();
        tick();
        test_reset();
        test_len4();
        test_idle_armed();
        test_full();
        test_clear();
        test_wrap();
        test_pop_empty();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
